// File: rtl/llr_former_fifo.sv
// llr_former_fifo
// Turns each aligned I/Q pair into a pair of symmetric, saturated soft values
// for the Fano decoder, then buffers the pairs in a small FIFO. The decoder can
// hold off with i_ready while it backtracks. Upstream is never stalled: when the
// FIFO is full and nothing is popped, the incoming pair is dropped and a sticky
// overflow flag is raised.

module llr_former_fifo #(
  parameter int DATA_WIDTH = 6,
  parameter int LLR_WIDTH  = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic signed [DATA_WIDTH-1:0] i_i,
  input  logic signed [DATA_WIDTH-1:0] i_q,
  input  logic                        i_valid,
  input  logic                        i_inv_i,
  input  logic                        i_inv_q,
  input  logic                        i_swap,
  input  logic [1:0]                  i_shift,
  output logic signed [LLR_WIDTH-1:0] o_llr0,
  output logic signed [LLR_WIDTH-1:0] o_llr1,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [ADDR_WIDTH:0]         o_level,
  output logic                        o_overflow
);

  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam int SAT_HI_I = (1 << (LLR_WIDTH - 1)) - 1;

  // Input extremes. Negating the most negative sample has no positive
  // counterpart, so it is clamped to the largest positive value instead.
  localparam logic signed [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  // Symmetric clamp limits in the input width. The output never shows
  // -2^(LLR_WIDTH-1), which keeps both rails sign-symmetric for the decoder.
  localparam logic signed [DATA_WIDTH-1:0] SAT_HI = DATA_WIDTH'(SAT_HI_I);
  localparam logic signed [DATA_WIDTH-1:0] SAT_LO = DATA_WIDTH'(-SAT_HI_I);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  // One rail: optional saturating negate, then arithmetic shift, then clamp.
  function automatic logic signed [LLR_WIDTH-1:0] mapRail(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic                         inv,
    input logic [1:0]                   sh
  );
    logic signed [DATA_WIDTH-1:0] v_neg;
    logic signed [DATA_WIDTH-1:0] v_shr;
    logic signed [DATA_WIDTH-1:0] v_sat;
    if (inv) begin
      v_neg = (x == D_MIN) ? D_MAX : -x;
    end else begin
      v_neg = x;
    end
    v_shr = v_neg >>> sh;
    if (v_shr > SAT_HI) begin
      v_sat = SAT_HI;
    end else if (v_shr < SAT_LO) begin
      v_sat = SAT_LO;
    end else begin
      v_sat = v_shr;
    end
    return v_sat[LLR_WIDTH-1:0];
  endfunction

  logic signed [LLR_WIDTH-1:0] w_railI;
  logic signed [LLR_WIDTH-1:0] w_railQ;
  logic signed [LLR_WIDTH-1:0] w_map0;
  logic signed [LLR_WIDTH-1:0] w_map1;

  logic                        r_s1Valid;
  logic signed [LLR_WIDTH-1:0] r_s1Llr0;
  logic signed [LLR_WIDTH-1:0] r_s1Llr1;

  logic signed [LLR_WIDTH-1:0] r_mem0 [DEPTH];
  logic signed [LLR_WIDTH-1:0] r_mem1 [DEPTH];
  logic [ADDR_WIDTH-1:0]       r_wrPtr;
  logic [ADDR_WIDTH-1:0]       r_rdPtr;
  logic [ADDR_WIDTH:0]         r_count;
  logic                        r_overflow;

  logic w_full;
  logic w_pop;
  logic w_wrEn;

  // Map both rails with the controls sampled alongside the data; swap goes last.
  always_comb begin
    w_railI = mapRail(i_i, i_inv_i, i_shift);
    w_railQ = mapRail(i_q, i_inv_q, i_shift);
    w_map0  = i_swap ? w_railQ : w_railI;
    w_map1  = i_swap ? w_railI : w_railQ;
  end

  // Stage 1 map register. Reset only drops the valid; the data is don't-care.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1Valid <= 1'b0;
    end else begin
      r_s1Valid <= i_valid;
      if (i_valid) begin
        r_s1Llr0 <= w_map0;
        r_s1Llr1 <= w_map1;
      end
    end
  end

  // A full FIFO still accepts a write when the head leaves on the same edge.
  always_comb begin
    w_full = (r_count == FULL_COUNT);
    w_pop  = (r_count != '0) && i_ready;
    w_wrEn = r_s1Valid && (!w_full || w_pop);
  end

  // Pair storage. It has no reset; the pointers decide what is live.
  always_ff @(posedge i_clk) begin
    if (w_wrEn) begin
      r_mem0[r_wrPtr] <= r_s1Llr0;
      r_mem1[r_wrPtr] <= r_s1Llr1;
    end
  end

  // Pointers, occupancy and the sticky drop flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wrEn) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_wrEn, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (r_s1Valid && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // The head pair is read straight from storage, with no same-cycle bypass.
  always_comb begin
    o_llr0     = r_mem0[r_rdPtr];
    o_llr1     = r_mem1[r_rdPtr];
    o_valid    = (r_count != '0);
    o_level    = r_count;
    o_overflow = r_overflow;
  end

endmodule

// File: tb/tb_llr_former_fifo.sv
// Testbench for llr_former_fifo. Directed vectors with hand-computed values,
// plus a small behavioural rail model and an expected-pair queue that check
// every popped head pair.

module tb_llr_former_fifo;

  localparam int DATA_WIDTH = 6;
  localparam int LLR_WIDTH  = 4;
  localparam int ADDR_WIDTH = 4;

  logic                         i_clk;
  logic                         i_reset;
  logic signed [DATA_WIDTH-1:0] i_i;
  logic signed [DATA_WIDTH-1:0] i_q;
  logic                         i_valid;
  logic                         i_inv_i;
  logic                         i_inv_q;
  logic                         i_swap;
  logic [1:0]                   i_shift;
  logic signed [LLR_WIDTH-1:0]  o_llr0;
  logic signed [LLR_WIDTH-1:0]  o_llr1;
  logic                         o_valid;
  logic                         i_ready;
  logic [ADDR_WIDTH:0]          o_level;
  logic                         o_overflow;

  typedef struct {
    int l0;
    int l1;
  } pair_t;

  pair_t expQ[$];
  int    checkCount = 0;
  int    errCount   = 0;

  llr_former_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .LLR_WIDTH (LLR_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_i       (i_i),
    .i_q       (i_q),
    .i_valid   (i_valid),
    .i_inv_i   (i_inv_i),
    .i_inv_q   (i_inv_q),
    .i_swap    (i_swap),
    .i_shift   (i_shift),
    .o_llr0    (o_llr0),
    .o_llr1    (o_llr1),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_level   (o_level),
    .o_overflow(o_overflow)
  );

  // 10-time-unit clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Reference rail: saturating negate, floor shift, symmetric clamp to +/-7.
  function automatic int modelRail(input int x, input bit inv, input int sh);
    int v;
    v = x;
    if (inv) v = (x == -32) ? 31 : -x;
    v = v >>> sh;
    if (v > 7)  v = 7;
    if (v < -7) v = -7;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Drive one cycle of inputs, record the pair if it should be accepted, check
  // the head against the expected queue if it pops on this edge, then clock.
  task automatic applyStimulus(input bit v, input int ii, input int qq,
                               input bit invI, input bit invQ, input bit swp,
                               input int sh, input bit rdy, input bit expAccept);
    pair_t p;
    int a;
    int b;
    i_valid = v;
    i_i     = ii[DATA_WIDTH-1:0];
    i_q     = qq[DATA_WIDTH-1:0];
    i_inv_i = invI;
    i_inv_q = invQ;
    i_swap  = swp;
    i_shift = sh[1:0];
    i_ready = rdy;
    if (v && expAccept) begin
      a    = modelRail(ii, invI, sh);
      b    = modelRail(qq, invQ, sh);
      p.l0 = swp ? b : a;
      p.l1 = swp ? a : b;
      expQ.push_back(p);
    end
    if (o_valid && rdy) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousPop", int'(o_valid), 0);
      end else begin
        p = expQ.pop_front();
        checkOutput("head0", int'(o_llr0), p.l0);
        checkOutput("head1", int'(o_llr1), p.l1);
      end
    end
    tick();
  endtask

  task automatic idle(input bit rdy);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, rdy, 1'b0);
  endtask

  task automatic doReset();
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    expQ.delete();
  endtask

  task automatic checkStatus(input string tag, input int v, input int lvl, input int ovf);
    checkOutput({tag, "_valid"}, int'(o_valid), v);
    checkOutput({tag, "_level"}, int'(o_level), lvl);
    checkOutput({tag, "_ovf"}, int'(o_overflow), ovf);
  endtask

  initial begin
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_i     = '0;
    i_q     = '0;
    i_inv_i = 1'b0;
    i_inv_q = 1'b0;
    i_swap  = 1'b0;
    i_shift = '0;
    i_ready = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;

    $display("[TB] reset and idle");
    checkStatus("reset", 0, 0, 0);
    for (int n = 0; n < 3; n++) begin
      idle(1'b1);
      checkStatus("idle", 0, 0, 0);
    end

    $display("[TB] single pair latency and saturation");
    applyStimulus(1'b1, 20, -5, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1);
    checkOutput("lat1_valid", int'(o_valid), 0);
    idle(1'b0);
    checkStatus("lat2", 1, 1, 0);
    checkOutput("lat2_llr0", int'(o_llr0), 7);
    checkOutput("lat2_llr1", int'(o_llr1), -3);
    idle(1'b1);
    checkStatus("popped", 0, 0, 0);

    $display("[TB] inversion, swap and shift");
    applyStimulus(1'b1, -32, -32, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b1);
    applyStimulus(1'b1, -32, -32, 1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b1);
    applyStimulus(1'b1, -9, 13, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b1);
    applyStimulus(1'b1, 5, -6, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    idle(1'b0);
    checkOutput("inv_level", int'(o_level), 4);
    checkOutput("inv_llr0", int'(o_llr0), 7);
    checkOutput("inv_llr1", int'(o_llr1), -7);
    idle(1'b1);
    checkOutput("swap_llr0", int'(o_llr0), -7);
    checkOutput("swap_llr1", int'(o_llr1), 7);
    idle(1'b1);
    checkOutput("shr_llr0", int'(o_llr0), 4);
    checkOutput("shr_llr1", int'(o_llr1), -7);
    idle(1'b1);
    checkOutput("mix_llr0", int'(o_llr0), -6);
    checkOutput("mix_llr1", int'(o_llr1), 5);
    idle(1'b1);
    checkStatus("invDone", 0, 0, 0);

    $display("[TB] fill past full with decoder stalled");
    for (int k = 0; k <= 16; k++) begin
      applyStimulus(1'b1, k, k - 8, 1'b0, 1'b0, 1'b0, 0, 1'b0, (k < 16));
    end
    idle(1'b0);
    checkStatus("full", 1, 16, 1);
    checkOutput("full_llr0", int'(o_llr0), 0);
    checkOutput("full_llr1", int'(o_llr1), -7);
    for (int j = 0; j < 16; j++) begin
      idle(1'b1);
      if (j == 7) checkOutput("halfDrain_level", int'(o_level), 8);
    end
    checkStatus("drained", 0, 0, 1);

    $display("[TB] reset mid-stream");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, k + 1, -(k + 1), 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    end
    checkOutput("preReset_level", int'(o_level), 5);
    doReset();
    checkStatus("midReset", 0, 0, 0);
    idle(1'b0);
    checkStatus("postReset", 0, 0, 0);
    applyStimulus(1'b1, 3, -2, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    idle(1'b0);
    checkStatus("fresh", 1, 1, 0);
    checkOutput("fresh_llr0", int'(o_llr0), 3);
    checkOutput("fresh_llr1", int'(o_llr1), -2);
    idle(1'b1);
    checkStatus("freshPopped", 0, 0, 0);

    $display("[TB] full FIFO with simultaneous push and pop");
    for (int k = 0; k < 30; k++) begin
      applyStimulus(1'b1, (k % 15) - 7, 7 - (k % 15), 1'b0, 1'b0, 1'b0, 0,
                    (k >= 17), 1'b1);
      if (k >= 16) checkOutput("steady_level", int'(o_level), 16);
    end
    idle(1'b1);
    checkStatus("steadyEnd", 1, 16, 0);
    for (int j = 0; j < 18; j++) begin
      idle(1'b1);
    end
    checkStatus("final", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
